// File: rtl/sdram_aref_ctrl.sv
// SDRAM auto-refresh engine: interval ticker, refresh debt tracking
// and PRECHARGE-ALL + AREF burst sequencing on arbiter grant.
module sdram_aref_ctrl #(
  parameter int REF_INTERVAL_CYC = 780,
  parameter int T_RP_CYC         = 2,
  parameter int T_RFC_CYC        = 7,
  parameter int BURST_MAX        = 2,
  parameter int MAX_DEBT         = 8,
  parameter int URGENT_TH        = 6,
  parameter int ADDR_W           = 13,
  parameter int BA_W             = 2
) (
  input  logic              clk_100,
  input  logic              rst_n_lock,
  input  logic              init_end,
  input  logic              aref_en,
  output logic              aref_req,
  output logic              aref_urgent,
  output logic              aref_end,
  output logic [3:0]        aref_cmd,
  output logic [BA_W-1:0]   aref_ba,
  output logic [ADDR_W-1:0] aref_addr,
  output logic [3:0]        debt_cnt,
  output logic              debt_ovf
);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  localparam int IW = $clog2(REF_INTERVAL_CYC + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int TMAX = (T_RP_CYC > T_RFC_CYC) ? T_RP_CYC : T_RFC_CYC;
  localparam int WW = $clog2(TMAX + 1);
  // WAIT states last T-1 cycles; the command cycle itself is the first
  localparam int RP_LD  = (T_RP_CYC > 1) ? T_RP_CYC - 2 : 0;
  localparam int RFC_LD = (T_RFC_CYC > 1) ? T_RFC_CYC - 2 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_RP,
    S_AREF,
    S_WAIT_RFC,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_icnt;
  logic [3:0]      r_debt;
  logic [3:0]      w_debt_nxt;
  logic [BW-1:0]   r_burst;
  logic [BW-1:0]   w_burst_nxt;
  logic [WW-1:0]   r_wait;
  logic [WW-1:0]   w_wait_nxt;
  logic [3:0]      r_cmd;
  logic            r_req;
  logic            r_urg;
  logic            r_end;
  logic            r_ovf;
  logic            w_tick;
  logic            w_issue;
  logic            w_ovf_set;
  logic            w_more;

  assign w_tick  = init_end && (r_icnt == IW'(REF_INTERVAL_CYC - 1));
  assign w_issue = (r_state == S_AREF);

  always_comb begin
    w_debt_nxt = r_debt;
    w_ovf_set  = 1'b0;
    if (w_tick && !w_issue) begin
      if (r_debt == 4'(MAX_DEBT)) w_ovf_set = 1'b1;
      else                        w_debt_nxt = r_debt + 4'd1;
    end else if (!w_tick && w_issue) begin
      w_debt_nxt = r_debt - 4'd1;
    end
  end

  assign w_burst_nxt = w_issue ? r_burst + BW'(1) : r_burst;
  assign w_more = (w_burst_nxt < BW'(BURST_MAX)) && (w_debt_nxt != 4'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    unique case (r_state)
      S_IDLE: begin
        if (aref_en && (r_debt != 4'd0)) w_state_nxt = S_PRE;
      end
      S_PRE: begin
        w_wait_nxt  = WW'(RP_LD);
        w_state_nxt = (T_RP_CYC > 1) ? S_WAIT_RP : S_AREF;
      end
      S_WAIT_RP: begin
        if (r_wait == '0) w_state_nxt = S_AREF;
        else              w_wait_nxt  = r_wait - WW'(1);
      end
      S_AREF: begin
        w_wait_nxt = WW'(RFC_LD);
        if (T_RFC_CYC > 1) w_state_nxt = S_WAIT_RFC;
        else               w_state_nxt = w_more ? S_AREF : S_DONE;
      end
      S_WAIT_RFC: begin
        if (r_wait == '0) w_state_nxt = w_more ? S_AREF : S_DONE;
        else              w_wait_nxt  = r_wait - WW'(1);
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100 or negedge rst_n_lock) begin
    if (!rst_n_lock) begin
      r_state <= S_IDLE;
      r_icnt  <= '0;
      r_debt  <= '0;
      r_burst <= '0;
      r_wait  <= '0;
      r_cmd   <= CMD_NOP;
      r_req   <= 1'b0;
      r_urg   <= 1'b0;
      r_end   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (!init_end) begin
      // sticky overflow survives the init clear
      r_state <= S_IDLE;
      r_icnt  <= '0;
      r_debt  <= '0;
      r_burst <= '0;
      r_wait  <= '0;
      r_cmd   <= CMD_NOP;
      r_req   <= 1'b0;
      r_urg   <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_icnt  <= w_tick ? '0 : r_icnt + IW'(1);
      r_debt  <= w_debt_nxt;
      r_burst <= (r_state == S_DONE) ? '0 : w_burst_nxt;
      r_wait  <= w_wait_nxt;
      r_ovf   <= r_ovf | w_ovf_set;
      r_cmd   <= (r_state == S_PRE)  ? CMD_PRE  :
                 (r_state == S_AREF) ? CMD_AREF : CMD_NOP;
      r_req   <= (r_debt != 4'd0) && (r_state == S_IDLE);
      r_urg   <= (r_debt >= 4'(URGENT_TH));
      r_end   <= (r_state == S_DONE);
    end
  end

  assign aref_cmd    = r_cmd;
  assign aref_ba     = '1;
  assign aref_addr   = '1;
  assign aref_req    = r_req;
  assign aref_urgent = r_urg;
  assign aref_end    = r_end;
  assign debt_cnt    = r_debt;
  assign debt_ovf    = r_ovf;

endmodule

// File: tb/tb_sdram_aref_ctrl.sv
// Bench for sdram_aref_ctrl: tick/debt vector table plus queued
// per-cycle expectations for each refresh service sequence.
module tb_sdram_aref_ctrl;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;

  logic        clk_100 = 1'b0;
  logic        rst_n_lock;
  logic        init_end;
  logic        aref_en;
  logic        aref_req;
  logic        aref_urgent;
  logic        aref_end;
  logic [3:0]  aref_cmd;
  logic [1:0]  aref_ba;
  logic [12:0] aref_addr;
  logic [3:0]  debt_cnt;
  logic        debt_ovf;

  int cyc = 0;
  int t0 = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int         e;
    logic [3:0] debt;
    logic       urg;
    logic       ovf;
    logic       req;
  } vec_t;

  typedef struct {
    logic [3:0] cmd;
    logic       aend;
    logic [3:0] debt;
    logic       req;
  } exp_t;

  vec_t vt [11];
  exp_t q [$];

  sdram_aref_ctrl #(
    .REF_INTERVAL_CYC(50)
  ) dut (
    .clk_100     (clk_100),
    .rst_n_lock  (rst_n_lock),
    .init_end    (init_end),
    .aref_en     (aref_en),
    .aref_req    (aref_req),
    .aref_urgent (aref_urgent),
    .aref_end    (aref_end),
    .aref_cmd    (aref_cmd),
    .aref_ba     (aref_ba),
    .aref_addr   (aref_addr),
    .debt_cnt    (debt_cnt),
    .debt_ovf    (debt_ovf)
  );

  always #5 clk_100 = ~clk_100;
  always @(posedge clk_100) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0d act=%0h exp=%0h", nm, cyc - t0, act, exp);
  endtask

  task automatic wait_rel(input int e);
    while (cyc < t0 + e) @(negedge clk_100);
  endtask

  task automatic chk_vec(input int i);
    wait_rel(vt[i].e);
    chk("vec_debt", debt_cnt, vt[i].debt);
    chk("vec_urg", aref_urgent, vt[i].urg);
    chk("vec_ovf", debt_ovf, vt[i].ovf);
    chk("vec_req", aref_req, vt[i].req);
  endtask

  // grant sampled at the next edge k; offsets are edges after k
  task automatic grant(input int n_aref, input logic [3:0] d_pre,
                       input logic [3:0] d_mid, input logic [3:0] d_post,
                       input int n_off, input bit hold);
    int   eo;
    exp_t x;
    eo = (n_aref == 2) ? 17 : 10;
    aref_en = 1'b1;
    for (int o = 1; o <= n_off; o++) begin
      x.cmd  = (o == 1) ? PRE :
               ((o == 3) || (n_aref == 2 && o == 10)) ? AREF : NOP;
      x.aend = (o == eo);
      x.debt = (o < 3) ? d_pre : ((o < 10) ? d_mid : d_post);
      x.req  = (o > eo) && (d_post != 4'd0);
      q.push_back(x);
    end
    @(negedge clk_100);
    if (!hold) aref_en = 1'b0;
    for (int o = 1; o <= n_off; o++) begin
      @(negedge clk_100);
      if (o == 5) aref_en = 1'b0;
      x = q.pop_front();
      chk("seq_cmd", aref_cmd, x.cmd);
      chk("seq_end", aref_end, x.aend);
      chk("seq_debt", debt_cnt, x.debt);
      chk("seq_req", aref_req, x.req);
      chk("seq_addr", {aref_ba, aref_addr}, 15'h7fff);
    end
  endtask

  initial begin
    vt[0]  = '{50, 4'd1, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{51, 4'd1, 1'b0, 1'b0, 1'b1};
    vt[2]  = '{350, 4'd2, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{400, 4'd3, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{450, 4'd4, 1'b0, 1'b0, 1'b1};
    vt[5]  = '{500, 4'd5, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{550, 4'd6, 1'b0, 1'b0, 1'b1};
    vt[7]  = '{551, 4'd6, 1'b1, 1'b0, 1'b1};
    vt[8]  = '{600, 4'd7, 1'b1, 1'b0, 1'b1};
    vt[9]  = '{650, 4'd8, 1'b1, 1'b0, 1'b1};
    vt[10] = '{700, 4'd8, 1'b1, 1'b1, 1'b1};

    rst_n_lock = 1'b0;
    init_end   = 1'b0;
    aref_en    = 1'b0;
    repeat (3) @(negedge clk_100);
    chk("rst_cmd", aref_cmd, NOP);
    chk("rst_addr", {aref_ba, aref_addr}, 15'h7fff);
    chk("rst_req", aref_req, 1'b0);
    chk("rst_urg", aref_urgent, 1'b0);
    chk("rst_end", aref_end, 1'b0);
    chk("rst_debt", debt_cnt, 4'd0);
    chk("rst_ovf", debt_ovf, 1'b0);
    rst_n_lock = 1'b1;
    repeat (2) @(negedge clk_100);
    init_end = 1'b1;
    t0 = cyc;

    for (int e = 1; e <= 49; e++) begin
      wait_rel(e);
      chk("idle_nop", {aref_cmd, aref_end, debt_cnt}, {NOP, 1'b0, 4'd0});
    end
    chk_vec(0);
    chk_vec(1);
    chk("first_nop", aref_cmd, NOP);

    grant(1, 4'd1, 4'd0, 4'd0, 11, 1'b0);

    wait_rel(70);
    aref_en = 1'b1;
    wait_rel(71);
    aref_en = 1'b0;
    for (int e = 71; e <= 90; e++) begin
      wait_rel(e);
      chk("zero_debt_en", {aref_cmd, aref_end}, {NOP, 1'b0});
    end

    wait_rel(200);
    grant(2, 4'd3, 4'd2, 4'd1, 18, 1'b1);

    wait_rel(296);
    grant(2, 4'd2, 4'd2, 4'd1, 18, 1'b0);

    for (int i = 2; i <= 10; i++) chk_vec(i);

    grant(2, 4'd8, 4'd7, 4'd6, 18, 1'b0);
    chk("post_ovf", debt_ovf, 1'b1);
    chk("post_urg", aref_urgent, 1'b1);

    wait_rel(720);
    init_end = 1'b0;
    wait_rel(721);
    chk("clr_debt", debt_cnt, 4'd0);
    chk("clr_ovf_held", debt_ovf, 1'b1);
    wait_rel(722);
    chk("clr_req", aref_req, 1'b0);
    chk("clr_urg", aref_urgent, 1'b0);

    wait_rel(730);
    init_end = 1'b1;
    wait_rel(779);
    chk("re_debt0", debt_cnt, 4'd0);
    wait_rel(780);
    chk("re_debt1", debt_cnt, 4'd1);
    grant(1, 4'd1, 4'd0, 4'd0, 5, 1'b0);

    rst_n_lock = 1'b0;
    #1;
    chk("mid_rst_cmd", aref_cmd, NOP);
    chk("mid_rst_addr", {aref_ba, aref_addr}, 15'h7fff);
    chk("mid_rst_debt", debt_cnt, 4'd0);
    chk("mid_rst_ovf", debt_ovf, 1'b0);
    chk("mid_rst_end", aref_end, 1'b0);
    wait_rel(788);
    init_end   = 1'b0;
    rst_n_lock = 1'b1;
    for (int e = 800; e <= 950; e += 50) begin
      wait_rel(e);
      chk("no_tick", {aref_cmd, aref_req, debt_cnt}, {NOP, 1'b0, 4'd0});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sdram_aref_ctrl.md
Name: sdram_aref_ctrl

Overview:
- Parametrised SDRAM auto-refresh engine for the SDRAM controller.
- Generates refresh ticks from a programmable interval and tracks postponed refreshes in a debt counter.
- On arbiter grant, issues PRECHARGE-ALL followed by a burst of AUTO REFRESH commands, honouring tRP/tRFC.
- Sits beside the init and read/write engines. The arbiter muxes its cmd/ba/addr onto the SDRAM bus once init_end=1.

Parameters:
- REF_INTERVAL_CYC, 780, clk_100 cycles between refresh ticks (64 ms / 8192 rows at 100 MHz, with margin).
- T_RP_CYC, 2, cycles from PRECHARGE to the next command (>=1).
- T_RFC_CYC, 7, cycles from AREF to the next command (>=1).
- BURST_MAX, 2, maximum AREF commands per grant (>=1).
- MAX_DEBT, 8, debt saturation limit (JEDEC postpone limit).
- URGENT_TH, 6, debt level at which aref_urgent asserts.
- ADDR_W, 13, SDRAM address width.
- BA_W, 2, bank address width.

Ports:
- clk_100  in  1  100 MHz controller clock
- rst_n_lock  in  1  asynchronous active-low reset (PLL locked AND rst_n)
- init_end  in  1  init sequence complete; level
- aref_en  in  1  arbiter grant; sampled only in IDLE
- aref_req  out  1  refresh pending (debt>0 and FSM in IDLE)
- aref_urgent  out  1  debt >= URGENT_TH; arbiter must grant ahead of R/W
- aref_end  out  1  one-cycle pulse when the service sequence completes
- aref_cmd  out  4  {cs_n,ras_n,cas_n,we_n}
- aref_ba  out  BA_W  bank address
- aref_addr  out  ADDR_W  address
- debt_cnt  out  4  outstanding refreshes, 0..MAX_DEBT
- debt_ovf  out  1  sticky: a tick arrived while debt==MAX_DEBT

Behaviour:
- Reset is asynchronous on rst_n_lock, active-low; all logic runs on clk_100.
- Command encodings: NOP=4'b0111, PRECHARGE=4'b0010, AREF=4'b0001.
- aref_ba is always all-ones and aref_addr is always all-ones, so A10=1 selects precharge-all.
- All outputs are registered.
- Reset values:
  - cmd=NOP, ba/addr all-ones.
  - aref_req=0, aref_urgent=0, aref_end=0.
  - debt_cnt=0, debt_ovf=0.
  - FSM=IDLE, interval counter=0.
- init_end=0 acts as a synchronous clear: interval counter, debt and FSM return to reset values; debt_ovf is held.
- Interval counter runs only while init_end=1. It counts 0..REF_INTERVAL_CYC-1 and wraps.
- A tick fires on the wrap cycle, so the first tick comes REF_INTERVAL_CYC cycles after init_end rises.
- Debt update on each tick:
  - Tick: debt+1, saturating at MAX_DEBT.
  - Tick at MAX_DEBT: debt unchanged and debt_ovf set (cleared only by reset).
  - AREF issue: debt-1.
  - Tick and AREF issue in the same cycle: debt unchanged.
- aref_req = (debt!=0) && FSM==IDLE, registered; it deasserts the cycle after the grant is taken.
- aref_urgent follows debt_cnt >= URGENT_TH, registered.
- FSM states: IDLE, PRE, WAIT_RP, AREF, WAIT_RFC, DONE.
  - IDLE: aref_en=1 and debt>0 -> PRE. aref_en with debt=0 is ignored and produces no aref_end.
  - PRE: cmd=PRECHARGE for 1 cycle -> WAIT_RP.
  - WAIT_RP: NOP until T_RP_CYC cycles have elapsed since PRE -> AREF.
  - AREF: cmd=AREF for 1 cycle; debt decrements and the burst counter increments -> WAIT_RFC.
  - WAIT_RFC: NOP until T_RFC_CYC cycles have elapsed since the AREF.
    - If burst count < BURST_MAX and debt>0 at that point -> AREF.
    - Otherwise -> DONE.
  - DONE: aref_end=1 for one cycle, cmd=NOP -> IDLE; burst counter clears.
- Timing with defaults, grant sampled at edge k:
  - PRE at k+1, AREF at k+3, AREF at k+10.
  - aref_end at k+17.
- aref_en deasserting mid-sequence is ignored; the sequence always completes.
- A tick during a sequence is counted normally and may extend the burst up to BURST_MAX.

Test Plan:
- REF_INTERVAL_CYC=50, reset, init_end rises at cycle 0 -> aref_req rises at cycle 51; cmd NOP throughout; debt_cnt=1.
- Defaults, debt=1, aref_en pulse at edge k -> PRE(0010, A10=1) at k+1, AREF(0001) at k+3, aref_end at k+10; debt_cnt=0, only one AREF issued.
- Debt=3, BURST_MAX=2, grant -> two AREFs spaced 7 cycles apart, aref_end, debt_cnt=1, aref_req reasserts the next cycle.
- No grant for 9 ticks -> debt saturates at 8; aref_urgent=1 from debt=6; debt_ovf=1 after the ninth tick and stays set after service.
- Tick coincides with an AREF issue -> debt_cnt unchanged; aref_en dropped mid-sequence -> sequence completes with aref_end.
- Reset asserted mid-WAIT_RFC -> immediate NOP and all-ones addr, debt_cnt=0, FSM IDLE; init_end deasserted -> no further ticks.
